// File: rtl/fetch_unit_pkg.sv
// Shared core constants and types for the instruction-fetch front end.
package fetch_unit_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

  // One buffered fetch: the instruction word tagged with its address.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

  // Drop the byte offset so every fetch address is word-aligned.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, instr} entries.
// Flush empties it in one cycle; the caller never pushes when full
// and never pops when empty.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  input  logic          flush,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage, pointers and occupancy; flush wins over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, credit-based issue to a 1-cycle
// program memory, response buffering and redirect handling.
// Handshake: an instruction transfers on a cycle where instr_valid and
// instr_ready are both high; while instr_valid is high and instr_ready
// is low, instr/instr_pc/instr_valid stay stable.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        misalign
);

  localparam int CW = $clog2(DEPTH + 1);

  logic          running;         // high from the first edge out of reset
  logic [31:0]   pc;
  logic          outstanding;
  logic [31:0]   outstanding_pc;
  logic [CW-1:0] count;
  logic          pop;
  logic          push;
  logic [31:0]   used;
  logic          credit;
  fetch_entry_t  head;
  fetch_entry_t  resp;

  assign pop    = instr_valid & instr_ready;
  assign used   = 32'(count) + 32'(outstanding);
  assign credit = used < (32'(DEPTH) + 32'(pop));

  // A redirect cycle never issues, so nothing from the old stream is
  // requested once the redirect is seen. The response arriving in the
  // redirect cycle itself is the only stale one and is discarded here.
  assign mem_req  = running & credit & ~redirect_valid;
  assign mem_addr = pc;
  assign push     = outstanding & ~redirect_valid;
  assign misalign = redirect_valid & (redirect_target[1:0] != 2'b00);

  assign resp.pc    = outstanding_pc;
  assign resp.instr = mem_rdata;

  // PC, in-flight tracking and redirect handling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running        <= 1'b0;
      pc             <= RESET_PC;
      outstanding    <= 1'b0;
      outstanding_pc <= '0;
    end else begin
      running <= 1'b1;
      if (redirect_valid) begin
        pc          <= align_word(redirect_target);
        outstanding <= 1'b0;
      end else begin
        outstanding <= mem_req;
        if (mem_req) begin
          outstanding_pc <= pc;
          pc             <= pc + 32'd4;
        end
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (resp),
    .pop   (pop),
    .flush (redirect_valid),
    .rdata (head),
    .count (count)
  );

  assign instr_valid = (count != '0);
  assign instr       = head.instr;
  assign instr_pc    = head.pc;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch front end of the RV32I core: owns the program counter, issues word reads to the program memory, buffers returned instructions in a small FIFO, and hands them to decode over a valid/ready handshake. It sits directly upstream of decode/execute and accepts PC redirects from the branch/jump resolution logic (JAL, JALR, taken Bxx). It discards stale in-flight fetches after a redirect.

## Interface

- RESET_PC, 32'h0000_0000, PC fetched first after reset
- DEPTH, 2, instruction buffer entries (≥2)

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- mem_req  out  1  program-memory read request this cycle
- mem_addr  out  32  byte address, always word-aligned
- mem_rdata  in  32  read data, valid the cycle after mem_req (fixed 1-cycle latency, memory always ready)
- redirect_valid  in  1  branch/jump resolved taken this cycle
- redirect_target  in  32  new PC
- instr_valid  out  1  instr/instr_pc valid
- instr_ready  in  1  decode accepts this cycle
- instr  out  32  instruction word
- instr_pc  out  32  PC of instr
- misalign  out  1  one-cycle pulse: redirect_target[1:0] != 0

## Operation

- Registers: pc (next fetch address), outstanding (0/1), outstanding_pc, drop flag, FIFO of {pc, instr}, count.
- Issue rule: mem_req = 1 when (count + outstanding − pop) < DEPTH and not in reset; pop = instr_valid & instr_ready. On issue, pc ← pc + 4 (wraps modulo 2^32, 32'hFFFF_FFFC → 0).
- Response: cycle after an issue, mem_rdata pushed with outstanding_pc unless drop is set.
- Redirect (highest priority): FIFO cleared, count ← 0; any in-flight response marked drop; pc ← {redirect_target[31:2], 2'b00}; no mem_req in the redirect cycle. An instruction handshaked in the same cycle counts as consumed.
- Misaligned target: misalign pulses that cycle; fetch proceeds from the truncated address (exception handling lives downstream).
- Simultaneous push and pop: count unchanged; full FIFO never overflows by construction of the issue rule.
- instr_ready low: instr/instr_pc/instr_valid held stable until accepted.
- Reset (any time, including mid-fetch): everything cleared asynchronously; in-flight data ignored.

## Timing

- Reset values: mem_req 0, mem_addr RESET_PC, instr_valid 0, instr 0, instr_pc 0, misalign 0.
- Cycle 0 = first edge with rst_n high: mem_req=1, mem_addr=RESET_PC during cycle 0; instr_valid=1 with instr_pc=RESET_PC from cycle 2.
- Steady state with instr_ready held high: one instruction per cycle, consecutive PCs.
- Redirect in cycle k: instr_valid low in k+1 and k+2; mem_addr=target in k+1; target instruction valid in k+3 (redirect-to-use 3 cycles).
- instr_ready low for N cycles: at most DEPTH buffered, mem_req low once full, resumes the cycle pop frees a credit.

## Structure

- Shared core package: RESET_PC default, XLEN=32, ILEN=32, NOP constant 32'h0000_0013.
- Sub-module fetch_fifo: parameterised DEPTH×64-bit synchronous FIFO with push, pop, flush, count, async reset; fetch_unit holds PC, credit and drop logic.

## Test plan

- Reset release, memory words 0..3 preloaded, instr_ready=1 -> instr_pc 0,4,8,12 in cycles 2,3,4,5 with matching instr.
- instr_ready=0 for cycles 3–8 -> instr_pc=4 held stable, mem_req low once 2 entries buffered, no loss/duplication after ready returns.
- redirect_valid in cycle 4 to 32'h40 (JAL model) -> in-flight word dropped, instr_valid low cycles 5–6, instr_pc=32'h40 in cycle 7, then 32'h44.
- redirect to 32'h42 -> misalign=1 for exactly that cycle, next instr_pc=32'h40.
- Back-to-back redirects (cycles 4 and 5, targets 0x80 then 0x20) -> no 0x80 instruction delivered; first delivered PC 0x20 in cycle 8.
- rst_n asserted mid-fetch with full FIFO -> outputs return to reset values immediately; after release fetch restarts at RESET_PC.
